spi_dual_slave_system: RTL and testbench



---
 rtl/spi_dual_slave_system.sv | 200 ++++++++++++++++++++
 tb/tb_spi_dual_slave_system.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_dual_slave_system.sv
// SPI mode-3 master with two internal slaves (echo, complement echo).
// Ports: clk, rst, lev, i_TX_DV_M, i_TX_Byte_M, SPI_Code in;
//   o_TX_Ready_M, o_RX_DV_M, o_RX_Byte_M out.
//   SPI_DBG_PORTS_EN adds o_SPI_Clk, o_SPI_MOSI, o_SPI_MISO, o_SPI_CS_n.
`timescale 1ns/1ps
module spi_dual_slave_system #(
  parameter int SPI_MODE          = 3,
  parameter int CLKS_PER_HALF_BIT = 4,
  parameter int DATABITS          = 8,
  parameter int SPI_SIZE          = 2,
  parameter int SS_SIZE           = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                lev,
  input  logic                i_TX_DV_M,
  input  logic [DATABITS-1:0] i_TX_Byte_M,
  input  logic [SPI_SIZE-1:0] SPI_Code,
  output logic                o_TX_Ready_M,
  output logic                o_RX_DV_M,
  output logic [DATABITS-1:0] o_RX_Byte_M
`ifdef SPI_DBG_PORTS_EN
  ,
  output logic                o_SPI_Clk,
  output logic                o_SPI_MOSI,
  output logic                o_SPI_MISO,
  output logic [SS_SIZE-1:0]  o_SPI_CS_n
`endif
);

  localparam logic CPOL = (SPI_MODE >= 2);
  localparam int HW =
    (CLKS_PER_HALF_BIT > 1) ? $clog2(CLKS_PER_HALF_BIT) : 1;
  localparam int EW = $clog2(2 * DATABITS);
  localparam logic [HW-1:0] HC_MAX = HW'(CLKS_PER_HALF_BIT - 1);
  localparam logic [EW-1:0] EC_MAX = EW'(2 * DATABITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    DONE
  } state_t;

  state_t state, state_nx;

  logic                sclk;
  logic                mosi;
  logic                miso;
  logic [SS_SIZE-1:0]  cs_n;
  logic [SS_SIZE-1:0]  s_miso;
  logic [HW-1:0]       hc;
  logic [EW-1:0]       ec;
  logic [DATABITS-1:0] tx_sh;
  logic [DATABITS-1:0] rx_sh;
  logic [SPI_SIZE-1:0] code_q;
  logic                accept;
  logic                half_end;

  assign o_TX_Ready_M = (state == IDLE);
  assign accept       = o_TX_Ready_M & lev & i_TX_DV_M;
  assign half_end     = (state == SHIFT) && (hc == HC_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     if (accept) state_nx = CS_SETUP;
      CS_SETUP: state_nx = SHIFT;
      SHIFT:    if (half_end && ec == EC_MAX) state_nx = DONE;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk        <= CPOL;
      mosi        <= 1'b0;
      hc          <= '0;
      ec          <= '0;
      tx_sh       <= '0;
      rx_sh       <= '0;
      code_q      <= '0;
      o_RX_DV_M   <= 1'b0;
      o_RX_Byte_M <= '0;
    end else begin
      o_RX_DV_M <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            tx_sh  <= i_TX_Byte_M;
            code_q <= SPI_Code;
            mosi   <= i_TX_Byte_M[DATABITS-1];
            hc     <= '0;
            ec     <= '0;
          end
        end
        SHIFT: begin
          if (half_end) begin
            hc   <= '0;
            ec   <= ec + 1'b1;
            sclk <= ~sclk;
            if (sclk) begin
              // first falling edge keeps the MSB set up in CS_SETUP
              if (ec != '0) begin
                tx_sh <= tx_sh << 1;
                mosi  <= tx_sh[DATABITS-2];
              end
            end else begin
              rx_sh <= {rx_sh[DATABITS-2:0], miso};
            end
          end else begin
            hc <= hc + 1'b1;
          end
        end
        DONE: begin
          o_RX_DV_M   <= 1'b1;
          o_RX_Byte_M <= rx_sh;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cs_n = '1;
    if (state != IDLE) begin
      for (int i = 0; i < SS_SIZE; i++) begin
        if (code_q == SPI_SIZE'(1 << i)) cs_n[i] = 1'b0;
      end
    end
  end

  // undriven bus floats high through the pull-up
  always_comb begin
    miso = 1'b1;
    for (int i = 0; i < SS_SIZE; i++) begin
      if (!cs_n[i]) miso = s_miso[i];
    end
  end

  for (genvar g = 0; g < SS_SIZE; g++) begin : g_slave
    localparam bit INV = (g % 2) == 1;

    logic [DATABITS-1:0] hold;
    logic [DATABITS-1:0] tx_s;
    logic [DATABITS-1:0] rx_s;
    logic                cs_q;
    logic                clk_q;
    logic                first;
    logic                sel;
    logic                rise;
    logic                fall;

    assign sel  = ~cs_n[g];
    assign rise = sel & ~clk_q & sclk;
    assign fall = sel & clk_q & ~sclk;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        hold  <= '0;
        tx_s  <= '0;
        rx_s  <= '0;
        cs_q  <= 1'b1;
        clk_q <= 1'b1;
        first <= 1'b0;
      end else begin
        cs_q  <= cs_n[g];
        clk_q <= sclk;
        if (sel && cs_q) begin
          tx_s  <= INV ? ~hold : hold;
          first <= 1'b1;
        end else if (fall) begin
          if (first) first <= 1'b0;
          else       tx_s  <= tx_s << 1;
        end
        if (rise) rx_s <= {rx_s[DATABITS-2:0], mosi};
        if (!sel && !cs_q) hold <= rx_s;
      end
    end

    assign s_miso[g] = tx_s[DATABITS-1];
  end

`ifdef SPI_DBG_PORTS_EN
  assign o_SPI_Clk  = sclk;
  assign o_SPI_MOSI = mosi;
  assign o_SPI_MISO = miso;
  assign o_SPI_CS_n = cs_n;
`endif

endmodule

// File: tb/tb_spi_dual_slave_system.sv
// Bench for spi_dual_slave_system: directed plus random transfers
// checked against a byte-level slave model.
`timescale 1ns/1ps
module tb_spi_dual_slave_system;

  logic       clk = 1'b0;
  logic       rst;
  logic       lev;
  logic       dv;
  logic [7:0] tx_byte;
  logic [1:0] code;
  logic       ready;
  logic       rx_dv;
  logic [7:0] rx_byte;
`ifdef SPI_DBG_PORTS_EN
  logic       dbg_clk;
  logic       dbg_mosi;
  logic       dbg_miso;
  logic [1:0] dbg_cs;
`endif

  spi_dual_slave_system dut (
    .clk          (clk),
    .rst          (rst),
    .lev          (lev),
    .i_TX_DV_M    (dv),
    .i_TX_Byte_M  (tx_byte),
    .SPI_Code     (code),
    .o_TX_Ready_M (ready),
    .o_RX_DV_M    (rx_dv),
    .o_RX_Byte_M  (rx_byte)
`ifdef SPI_DBG_PORTS_EN
    ,
    .o_SPI_Clk    (dbg_clk),
    .o_SPI_MOSI   (dbg_mosi),
    .o_SPI_MISO   (dbg_miso),
    .o_SPI_CS_n   (dbg_cs)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int rises  = 0;
  logic [7:0] hold [2];

  always @(negedge clk) if (rx_dv === 1'b1) pulses++;
`ifdef SPI_DBG_PORTS_EN
  always @(posedge dbg_clk) rises++;
`endif

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic [1:0] c,
                                       input logic [7:0] b);
    logic [7:0] r;
    case (c)
      2'b01:   begin r = hold[0];  hold[0] = b; end
      2'b10:   begin r = ~hold[1]; hold[1] = b; end
      default: r = 8'hFF;
    endcase
    return r;
  endfunction

  task automatic xfer(input logic [1:0] c, input logic [7:0] b,
                      input bit poke, input string tag);
    logic [7:0] exp;
    int lat, p0, r0;
    bit seen, busy_ok;
    lat = 0;
    while (ready !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    @(negedge clk);
    lev = 1'b1;
    code = c;
    tx_byte = b;
    dv = 1'b1;
    exp = model(c, b);
    p0 = pulses;
    r0 = rises;
    @(posedge clk);
    #1;
    dv = 1'b0;
    code = 2'($urandom);
    tx_byte = 8'($urandom);
    busy_ok = (ready === 1'b0);
    seen = 1'b0;
    lat = 0;
    while (!seen && lat < 200) begin
      @(posedge clk);
      lat++;
      #1;
      if (rx_dv === 1'b1) seen = 1'b1;
      else if (ready !== 1'b0) busy_ok = 1'b0;
      if (poke && lat == 20) begin
        dv = 1'b1;
        code = c;
        tx_byte = ~b;
      end
      if (poke && lat == 21) dv = 1'b0;
`ifdef SPI_DBG_PORTS_EN
      if (lat == 30)
        chk($sformatf("%s cs0", tag), 32'(dbg_cs[0]),
            32'(c != 2'b01));
`endif
    end
    chk($sformatf("%s latency", tag), lat, 66);
    chk($sformatf("%s rx_byte", tag), rx_byte, exp);
    chk($sformatf("%s ready_at_dv", tag), ready, 1);
    chk($sformatf("%s busy", tag), busy_ok, 1);
    @(negedge clk);
    @(negedge clk);
    chk($sformatf("%s pulses", tag), pulses - p0, 1);
    chk($sformatf("%s hold", tag), rx_byte, exp);
`ifdef SPI_DBG_PORTS_EN
    chk($sformatf("%s sclk_rises", tag), rises - r0, 8);
    chk($sformatf("%s sclk_idle", tag), dbg_clk, 1);
`endif
  endtask

  initial begin
    int p0;
    logic [1:0] rc;
    logic [7:0] rb;
    hold[0] = 8'h00;
    hold[1] = 8'h00;
    rst = 1'b1;
    lev = 1'b0;
    dv = 1'b0;
    code = 2'b00;
    tx_byte = 8'h00;
    #1;
    chk("reset ready", ready, 1);
    chk("reset rx_dv", rx_dv, 0);
    chk("reset rx_byte", rx_byte, 0);
`ifdef SPI_DBG_PORTS_EN
    chk("reset sclk", dbg_clk, 1);
    chk("reset cs", dbg_cs, 2'b11);
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;

    xfer(2'b00, 8'h00, 1'b0, "none");
    xfer(2'b01, 8'h11, 1'b0, "s0_a");
    xfer(2'b01, 8'h25, 1'b0, "s0_b");
    xfer(2'b01, 8'h41, 1'b1, "s0_c");
    xfer(2'b01, 8'h82, 1'b0, "s0_d");
    xfer(2'b10, 8'h25, 1'b0, "s1_a");
    xfer(2'b10, 8'h11, 1'b1, "s1_b");
    xfer(2'b10, 8'h11, 1'b0, "s1_c");

    @(negedge clk);
    lev = 1'b0;
    code = 2'b01;
    tx_byte = 8'h99;
    dv = 1'b1;
    @(negedge clk);
    dv = 1'b0;
    p0 = pulses;
    repeat (80) @(negedge clk);
    chk("lev0 pulses", pulses - p0, 0);
    chk("lev0 ready", ready, 1);
    lev = 1'b1;
    xfer(2'b01, 8'h33, 1'b0, "s0_after_lev0");

    @(negedge clk);
    code = 2'b01;
    tx_byte = 8'h77;
    dv = 1'b1;
    @(posedge clk);
    #1;
    dv = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("pre_rst busy", ready, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst ready", ready, 1);
    chk("mid_rst rx_dv", rx_dv, 0);
    chk("mid_rst rx_byte", rx_byte, 0);
    hold[0] = 8'h00;
    hold[1] = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    xfer(2'b01, 8'h5A, 1'b0, "after_rst");

    for (int i = 0; i < 25; i++) begin
      rc = 2'($urandom_range(0, 3));
      rb = 8'($urandom);
      xfer(rc, rb, 1'($urandom), $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
